// File: rtl/multi_ball_renderer.sv
// multi_ball_renderer: draws NUM_BALLS bouncing balls with drop shadows on a solid background.
// Positions advance once per frame during vblank; pixel colour comes from a 2-stage pipeline.
module multi_ball_renderer #(
  parameter int NUM_BALLS     = 2,
  parameter int BALL_SIZE     = 20,
  parameter int SHADOW_MARGIN = 4,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] speed,
  input  logic       pause,
  output logic [5:0] rgb,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       busy
);

  localparam logic [10:0] X_MIN    = 11'(BALL_SIZE);
  localparam logic [10:0] X_MAX    = 11'(H_RES - 1 - BALL_SIZE);
  localparam logic [10:0] Y_MIN    = 11'(BALL_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(V_RES - 1 - BALL_SIZE);
  localparam logic [20:0] R_BALL2  = 21'(BALL_SIZE * BALL_SIZE);
  localparam logic [20:0] R_SHAD2  = 21'((BALL_SIZE + SHADOW_MARGIN) * (BALL_SIZE + SHADOW_MARGIN));
  localparam logic [1:0]  LAST_IDX = 2'(NUM_BALLS - 1);
  localparam logic [5:0]  C_SHADOW = 6'b01_01_01;
  localparam logic [5:0]  C_BG     = 6'b00_00_10;

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  function automatic logic [10:0] init_x(input int i);
    return 11'(BALL_SIZE + ((i + 1) * (H_RES - 2 * BALL_SIZE)) / (NUM_BALLS + 1));
  endfunction

  // Returns {new_dir, new_pos}; clamps to the wall and reflects on contact.
  function automatic logic [11:0] axis_step(input logic [10:0] p, input logic dir,
                                            input logic [2:0] spd,
                                            input logic [10:0] lo, input logic [10:0] hi);
    logic [10:0] sum;
    logic [10:0] lim;
    sum = p + {8'd0, spd};
    lim = lo + {8'd0, spd};
    if (spd == 3'd0)  return {dir, p};
    if (dir) begin
      if (sum >= hi)  return {1'b0, hi};
      else            return {1'b1, sum};
    end else begin
      if (p < lim)    return {1'b1, lo};
      else            return {1'b0, p - {8'd0, spd}};
    end
  endfunction

  function automatic logic [9:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? 10'(a - b) : 10'(b - a);
  endfunction

  function automatic logic [5:0] palette(input int i);
    case (i)
      0:       return 6'b11_10_00;
      1:       return 6'b11_00_00;
      2:       return 6'b00_11_00;
      default: return 6'b11_00_11;
    endcase
  endfunction

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [2:0]  spd_q;
  logic        busy_q;
  logic        trigger;

  logic [10:0] x_q    [NUM_BALLS];
  logic [10:0] y_q    [NUM_BALLS];
  logic        xdir_q [NUM_BALLS];
  logic        ydir_q [NUM_BALLS];
  logic [10:0] x_d    [NUM_BALLS];
  logic [10:0] y_d    [NUM_BALLS];
  logic        xdir_d [NUM_BALLS];
  logic        ydir_d [NUM_BALLS];

  logic [10:0] cur_x, cur_y;
  logic        cur_xdir, cur_ydir;
  logic [11:0] step_x, step_y;

  assign trigger = (hpos == 10'd0) && (vpos == 10'(V_RES)) && !pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      spd_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (trigger) begin
          state_q <= S_UPDATE;
          idx_q   <= 2'd0;
          spd_q   <= speed;
          busy_q  <= 1'b1;
        end
        S_UPDATE: if (idx_q == LAST_IDX) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else begin
          idx_q   <= idx_q + 2'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // One shared step per axis, steered to the ball selected by idx_q.
  always_comb begin
    cur_x    = '0;
    cur_y    = '0;
    cur_xdir = 1'b0;
    cur_ydir = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (idx_q == 2'(i)) begin
        cur_x    = x_q[i];
        cur_y    = y_q[i];
        cur_xdir = xdir_q[i];
        cur_ydir = ydir_q[i];
      end
    end
    step_x = axis_step(cur_x, cur_xdir, spd_q, X_MIN, X_MAX);
    step_y = axis_step(cur_y, cur_ydir, spd_q, Y_MIN, Y_MAX);
    for (int i = 0; i < NUM_BALLS; i++) begin
      x_d[i]    = x_q[i];
      y_d[i]    = y_q[i];
      xdir_d[i] = xdir_q[i];
      ydir_d[i] = ydir_q[i];
      if (state_q == S_UPDATE && idx_q == 2'(i)) begin
        x_d[i]    = step_x[10:0];
        y_d[i]    = step_y[10:0];
        xdir_d[i] = step_x[11];
        ydir_d[i] = step_y[11];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        x_q[i]    <= init_x(i);
        y_q[i]    <= 11'(V_RES / 2);
        xdir_q[i] <= ((i & 1) == 0);
        ydir_q[i] <= ((i & 2) == 0);
      end
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        xdir_q[i] <= xdir_d[i];
        ydir_q[i] <= ydir_d[i];
      end
    end
  end

  // Stage 1: per-ball distances plus delayed blanking and syncs.
  logic [9:0] dx_p1_d [NUM_BALLS];
  logic [9:0] dy_p1_d [NUM_BALLS];
  logic [9:0] dx_p1_q [NUM_BALLS];
  logic [9:0] dy_p1_q [NUM_BALLS];
  logic       de_p1_q, hs_p1_q, vs_p1_q;

  always_comb begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      dx_p1_d[i] = abs_diff({1'b0, hpos}, x_q[i]);
      dy_p1_d[i] = abs_diff({1'b0, vpos}, y_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        dx_p1_q[i] <= '0;
        dy_p1_q[i] <= '0;
      end
      de_p1_q <= 1'b0;
      hs_p1_q <= 1'b0;
      vs_p1_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        dx_p1_q[i] <= dx_p1_d[i];
        dy_p1_q[i] <= dy_p1_d[i];
      end
      de_p1_q <= display_on;
      hs_p1_q <= hsync_in;
      vs_p1_q <= vsync_in;
    end
  end

  // Stage 2: squared distance, hit tests and colour priority.
  logic [20:0] d2;
  logic        ball_any, shad_any;
  logic [5:0]  ball_col;
  logic [5:0]  rgb_p2_d, rgb_p2_q;
  logic        hs_p2_q, vs_p2_q;

  always_comb begin
    d2       = '0;
    ball_any = 1'b0;
    shad_any = 1'b0;
    ball_col = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      d2 = 21'(dx_p1_q[i]) * 21'(dx_p1_q[i]) + 21'(dy_p1_q[i]) * 21'(dy_p1_q[i]);
      if (d2 <= R_BALL2) begin
        ball_any = 1'b1;
        ball_col = palette(i);
      end
      if (d2 <= R_SHAD2) shad_any = 1'b1;
    end
    if (!de_p1_q)      rgb_p2_d = 6'b00_00_00;
    else if (ball_any) rgb_p2_d = ball_col;
    else if (shad_any) rgb_p2_d = C_SHADOW;
    else               rgb_p2_d = C_BG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2_q <= '0;
      hs_p2_q  <= 1'b0;
      vs_p2_q  <= 1'b0;
    end else begin
      rgb_p2_q <= rgb_p2_d;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
    end
  end

  assign rgb     = rgb_p2_q;
  assign hsync_o = hs_p2_q;
  assign vsync_o = vs_p2_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_multi_ball_renderer.sv
// Directed bench for multi_ball_renderer: one-ball and two-ball instances share all inputs.
module tb_multi_ball_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hpos = '0, vpos = '0;
  logic       display_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       pause = 1'b0;
  logic [5:0] rgb1, rgb2;
  logic       hs1, vs1, busy1, hs2, vs2, busy2;

  int n_total = 0;
  int n_bad   = 0;
  int b1, b2, s1, s2;

  localparam logic [5:0] ORANGE = 6'b11_10_00;
  localparam logic [5:0] RED    = 6'b11_00_00;
  localparam logic [5:0] SHADOW = 6'b01_01_01;
  localparam logic [5:0] BG     = 6'b00_00_10;

  always #5 clk = ~clk;

  multi_ball_renderer #(.NUM_BALLS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .speed(speed), .pause(pause),
    .rgb(rgb1), .hsync_o(hs1), .vsync_o(vs1), .busy(busy1));

  multi_ball_renderer #(.NUM_BALLS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .speed(speed), .pause(pause),
    .rgb(rgb2), .hsync_o(hs2), .vsync_o(vs2), .busy(busy2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive a pixel, then wait the two-stage latency.
  task automatic pix(input int h, input int v, input logic de);
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = de;
    repeat (2) @(negedge clk);
  endtask

  // One vblank trigger; counts busy cycles seen on each instance.
  task automatic frame(input logic p, output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    hpos = 10'd0;
    vpos = 10'd480;
    pause = p;
    @(negedge clk);
    vpos = 10'd481;
    repeat (5) begin
      if (busy1) c1++;
      if (busy2) c2++;
      @(negedge clk);
    end
    pause = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset mid-frame clears outputs immediately
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    pix(0, 0, 1'b1);
    @(negedge clk);
    chk("pre_rst_rgb", rgb1, BG);
    chk("pre_rst_hs", hs1, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_rgb", rgb1, 0);
    chk("rst_hs", hs1, 0);
    chk("rst_vs", vs1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_x0", dut2.x_q[0], 220);
    chk("rst_x1", dut2.x_q[1], 420);
    chk("rst_y0", dut2.y_q[0], 240);
    chk("rst_y1", dut2.y_q[1], 240);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pix(0, 0, 1'b1);

    // Latency and colours
    hpos = 10'd320;
    vpos = 10'd240;
    @(negedge clk);
    chk("lat_1clk", rgb1, BG);
    @(negedge clk);
    chk("lat_2clk", rgb1, ORANGE);
    pix(342, 240, 1'b1);
    chk("shadow_22", rgb1, SHADOW);
    pix(0, 0, 1'b1);
    chk("bg_00", rgb1, BG);
    pix(320, 240, 1'b0);
    chk("blank", rgb1, 0);
    hsync_in = 1'b1;
    @(negedge clk);
    hsync_in = 1'b0;
    chk("hs_d1", hs1, 0);
    @(negedge clk);
    chk("hs_d2", hs1, 1);
    @(negedge clk);
    chk("hs_d3", hs1, 0);

    // Motion: one frame at speed 2
    speed = 3'd2;
    frame(1'b0, b1, b2);
    chk("mot_busy1", b1, 1);
    chk("mot_busy2", b2, 2);
    chk("mot_x", dut1.x_q[0], 322);
    chk("mot_y", dut1.y_q[0], 242);
    pix(322, 242, 1'b1);
    chk("mot_probe", rgb1, ORANGE);
    pix(300, 242, 1'b1);
    chk("mot_edge", rgb1, SHADOW);

    // Wall reflection at speed 7
    do_reset();
    speed = 3'd7;
    repeat (43) frame(1'b0, b1, b2);
    chk("wall_x43", dut1.x_q[0], 619);
    chk("wall_dir43", dut1.xdir_q[0], 0);
    chk("wall_y43", dut1.y_q[0], 382);
    pix(619, 382, 1'b1);
    chk("wall_probe", rgb1, ORANGE);
    frame(1'b0, b1, b2);
    chk("wall_x44", dut1.x_q[0], 612);

    // Pause and zero speed
    do_reset();
    speed = 3'd3;
    s1 = 0;
    for (int k = 0; k < 5; k++) begin
      frame(1'b1, b1, b2);
      s1 += b1;
    end
    chk("pause_busy", s1, 0);
    chk("pause_x", dut1.x_q[0], 320);
    chk("pause_y", dut1.y_q[0], 240);
    speed = 3'd0;
    frame(1'b0, b1, b2);
    chk("spd0_busy", b1, 1);
    chk("spd0_x", dut1.x_q[0], 320);
    chk("spd0_y", dut1.y_q[0], 240);
    chk("spd0_dir", dut1.xdir_q[0], 1);

    // Overlap priority: balls converge after 14 frames at speed 7
    do_reset();
    speed = 3'd7;
    s2 = 0;
    for (int k = 0; k < 14; k++) begin
      frame(1'b0, b1, b2);
      s2 += b2;
    end
    chk("ovl_busy", s2, 28);
    chk("ovl_x0", dut2.x_q[0], 318);
    chk("ovl_x1", dut2.x_q[1], 322);
    chk("ovl_y0", dut2.y_q[0], 338);
    pix(320, 338, 1'b1);
    chk("ovl_both", rgb2, ORANGE);
    pix(341, 338, 1'b1);
    chk("ovl_ball1", rgb2, RED);
    pix(297, 338, 1'b1);
    chk("ovl_shadow", rgb2, SHADOW);

    // Reset in the middle of an update
    hpos = 10'd0;
    vpos = 10'd480;
    @(negedge clk);
    vpos = 10'd481;
    chk("mid_busy_a", busy2, 1);
    @(negedge clk);
    chk("mid_busy_b", busy2, 1);
    chk("mid_x0_upd", dut2.x_q[0], 325);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", busy2, 0);
    chk("mid_x0", dut2.x_q[0], 220);
    chk("mid_x1", dut2.x_q[1], 420);
    chk("mid_y0", dut2.y_q[0], 240);
    chk("mid_y1", dut2.y_q[1], 240);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    speed = 3'd0;
    frame(1'b0, b1, b2);
    chk("post_busy2", b2, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
